ahb_arbiter_gen: RTL and testbench

- Parametrised AHB slave-port arbiter. One instance per slave in the generated interconnect.
- Selects one of MASTER_NUM requesting masters, holds the grant for a whole burst, and re-arbitrates with zero bubble on the last accepted beat.
- Supersedes the per-slave, define-configured arbiters: the arbitration mode (fixed, round-robin, dynamic priority) is a parameter.
- Adds undefined-length INCR handling with a beat cap, and optional per-beat arbitration.

---
 rtl/ahb_arbiter_gen.sv | 167 ++++++++++++++++
 tb/tb_ahb_arbiter_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_gen.sv
// AHB slave-port arbiter: fixed, round-robin or dynamic-priority selection,
// grant held per burst, undefined INCR capped at MAX_INCR_BEATS.
module ahb_arbiter_gen #(
  parameter int MASTER_NUM     = 4,
  parameter int ARB_MODE       = 1,
  parameter int PRIOR_BIT      = 2,
  parameter int BURST_LOCK     = 1,
  parameter int MAX_INCR_BEATS = 16,
  localparam int MW            = $clog2(MASTER_NUM)
) (
  input  logic                            hclk,
  input  logic                            hreset_n,
  input  logic [MASTER_NUM-1:0]           hreq,
  input  logic [2:0]                      hburst,
  input  logic                            hready,
  input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
  output logic [MASTER_NUM-1:0]           hgrant,
  output logic [MW-1:0]                   hmaster,
  output logic                            hsel,
  output logic                            hlast
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [2:0] B_INCR = 3'd1;

  state_t                state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [MW-1:0]         master_q, master_d;
  logic [MW-1:0]         rr_q, rr_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [2:0]            burst_q, burst_d;
  logic [5:0]            limit_q, limit_d;

  logic [MW-1:0]        fp_idx, rr_idx, dp_idx, win_idx;
  logic                 rr_hit, dp_hit;
  logic [PRIOR_BIT-1:0] dp_best;
  int                   rr_j;
  logic                 win_vld, acc, first, own_req, last_beat;
  logic [2:0]           burst_e;
  logic [5:0]           limit_e;

  function automatic logic [5:0] burst_limit(input logic [2:0] b);
    case (b)
      3'd0:       burst_limit = 6'd1;
      3'd1:       burst_limit = 6'(MAX_INCR_BEATS);
      3'd2, 3'd3: burst_limit = 6'd4;
      3'd4, 3'd5: burst_limit = 6'd8;
      default:    burst_limit = 6'd16;
    endcase
  endfunction

  always_comb begin
    fp_idx = '0;
    for (int i = MASTER_NUM - 1; i >= 0; i--)
      if (hreq[i]) fp_idx = MW'(i);
  end

  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    rr_j   = 0;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      rr_j = (int'(rr_q) + k) % MASTER_NUM;
      if (!rr_hit && hreq[rr_j]) begin
        rr_hit = 1'b1;
        rr_idx = MW'(rr_j);
      end
    end
  end

  // strict '>' keeps the lowest index on a priority tie
  always_comb begin
    dp_idx  = '0;
    dp_best = '0;
    dp_hit  = 1'b0;
    for (int i = 0; i < MASTER_NUM; i++)
      if (hreq[i] &&
          (!dp_hit || hprior[i*PRIOR_BIT +: PRIOR_BIT] > dp_best)) begin
        dp_hit  = 1'b1;
        dp_best = hprior[i*PRIOR_BIT +: PRIOR_BIT];
        dp_idx  = MW'(i);
      end
  end

  assign win_vld = |hreq;
  assign win_idx = (ARB_MODE == 0) ? fp_idx :
                   (ARB_MODE == 2) ? dp_idx : rr_idx;

  assign acc     = (state_q == OWN) & hready;
  assign first   = (cnt_q == 5'd0);
  assign burst_e = first ? hburst : burst_q;
  assign limit_e = first ? burst_limit(hburst) : limit_q;
  assign own_req = |(hreq & grant_q);

  assign last_beat = ({1'b0, cnt_q} == limit_e - 6'd1)
                   || (burst_e == B_INCR && !own_req)
                   || (BURST_LOCK == 0);

  assign hlast = acc & last_beat & hreset_n;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    master_d = master_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    burst_d  = burst_q;
    limit_d  = limit_q;
    unique case (state_q)
      IDLE: begin
        if (hready && win_vld) begin
          state_d  = OWN;
          grant_d  = MASTER_NUM'(1) << win_idx;
          master_d = win_idx;
          rr_d     = win_idx;
          cnt_d    = '0;
        end
      end
      OWN: begin
        if (acc) begin
          if (first) begin
            burst_d = hburst;
            limit_d = burst_limit(hburst);
          end
          cnt_d = cnt_q + 5'd1;
          if (last_beat) begin
            cnt_d = '0;
            if (win_vld) begin
              grant_d  = MASTER_NUM'(1) << win_idx;
              master_d = win_idx;
              rr_d     = win_idx;
            end else begin
              state_d = IDLE;
              grant_d = '0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      master_q <= '0;
      rr_q     <= MW'(MASTER_NUM - 1);
      cnt_q    <= '0;
      burst_q  <= '0;
      limit_q  <= 6'd1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
      limit_q  <= limit_d;
    end
  end

  assign hgrant  = grant_q;
  assign hmaster = master_q;
  assign hsel    = |grant_q;

endmodule

// File: tb/tb_ahb_arbiter_gen.sv
// Bench for ahb_arbiter_gen: four configurations share one stimulus and
// are checked every cycle against a transaction-level owner/beat model.
module tb_ahb_arbiter_gen;

  logic       hclk;
  logic       hreset_n;
  logic [3:0] hreq;
  logic [2:0] hburst;
  logic       hready;
  logic [7:0] hprior;

  logic [3:0] g [4];
  logic [1:0] m [4];
  logic       s [4];
  logic       l [4];

  int tests  = 0;
  int failed = 0;

  // instance 0: RR locked, 1: fixed, 2: dynamic prio, 3: RR per-beat
  int mode [4] = '{1, 0, 2, 1};
  int lock [4] = '{1, 1, 1, 0};
  int own  [4];
  int done [4];
  int blen [4];
  int btyp [4];
  int rrp  [4];
  int mst  [4];

  ahb_arbiter_gen #(.ARB_MODE(1), .BURST_LOCK(1)) u_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst),
    .hready(hready), .hprior(hprior), .hgrant(g[0]), .hmaster(m[0]),
    .hsel(s[0]), .hlast(l[0]));

  ahb_arbiter_gen #(.ARB_MODE(0), .BURST_LOCK(1)) u_fp (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst),
    .hready(hready), .hprior(hprior), .hgrant(g[1]), .hmaster(m[1]),
    .hsel(s[1]), .hlast(l[1]));

  ahb_arbiter_gen #(.ARB_MODE(2), .BURST_LOCK(1)) u_dp (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst),
    .hready(hready), .hprior(hprior), .hgrant(g[2]), .hmaster(m[2]),
    .hsel(s[2]), .hlast(l[2]));

  ahb_arbiter_gen #(.ARB_MODE(1), .BURST_LOCK(0)) u_pb (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst),
    .hready(hready), .hprior(hprior), .hgrant(g[3]), .hmaster(m[3]),
    .hsel(s[3]), .hlast(l[3]));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int len_of(input int b);
    case (b)
      0:       return 1;
      1:       return 16;
      2, 3:    return 4;
      4, 5:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int pick(input int k);
    int w;
    int bp;
    w  = -1;
    bp = -1;
    if (mode[k] == 0) begin
      for (int i = 3; i >= 0; i--) if (hreq[i]) w = i;
    end else if (mode[k] == 1) begin
      for (int o = 1; o <= 4; o++) begin
        int j;
        j = (rrp[k] + o) % 4;
        if (w < 0 && hreq[j]) w = j;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        int p;
        p = (int'(hprior) >> (2 * i)) & 3;
        if (hreq[i] && p > bp) begin
          bp = p;
          w  = i;
        end
      end
    end
    return w;
  endfunction

  function automatic bit exp_last(input int k);
    int bt;
    int len;
    if (!hreset_n || own[k] < 0 || !hready) return 1'b0;
    if (lock[k] == 0) return 1'b1;
    bt  = (done[k] == 0) ? int'(hburst) : btyp[k];
    len = (done[k] == 0) ? len_of(int'(hburst)) : blen[k];
    return (done[k] == len - 1) || (bt == 1 && !hreq[own[k]]);
  endfunction

  task automatic give(input int k, input int w);
    own[k]  = w;
    mst[k]  = w;
    rrp[k]  = w;
    done[k] = 0;
  endtask

  task automatic advance(input int k);
    int w;
    bit lst;
    if (!hreset_n) begin
      own[k]  = -1;
      done[k] = 0;
      rrp[k]  = 3;
      mst[k]  = 0;
    end else if (hready) begin
      if (own[k] < 0) begin
        w = pick(k);
        if (w >= 0) give(k, w);
      end else begin
        lst = exp_last(k);
        if (done[k] == 0) begin
          blen[k] = len_of(int'(hburst));
          btyp[k] = int'(hburst);
        end
        if (lst) begin
          w = pick(k);
          done[k] = 0;
          if (w >= 0) give(k, w);
          else own[k] = -1;
        end else begin
          done[k]++;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge hclk);
    for (int k = 0; k < 4; k++) begin
      int eg;
      eg = (own[k] < 0) ? 0 : (1 << own[k]);
      chk($sformatf("grant%0d", k), 32'(g[k]), eg);
      chk($sformatf("master%0d", k), 32'(m[k]), mst[k]);
      chk($sformatf("sel%0d", k), 32'(s[k]), (own[k] >= 0) ? 1 : 0);
      chk($sformatf("last%0d", k), 32'(l[k]), 32'(exp_last(k)));
    end
    for (int k = 0; k < 4; k++) advance(k);
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [2:0] b,
                       input logic rdy);
    hreq   = r;
    hburst = b;
    hready = rdy;
  endtask

  task automatic drain();
    drive(4'h0, 3'd0, 1'b1);
    repeat (20) step();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      own[k]  = -1;
      done[k] = 0;
      blen[k] = 1;
      btyp[k] = 0;
      rrp[k]  = 3;
      mst[k]  = 0;
    end
    hreset_n = 1'b0;
    hprior   = 8'hDC;
    drive(4'hF, 3'd0, 1'b1);
    step();
    step();

    hreset_n = 1'b1;
    #1;
    chk("rst_grant", 32'(g[0]), 0);
    chk("rst_sel", 32'(s[0]), 0);
    chk("rst_master", 32'(m[0]), 0);
    step();
    chk("rr_first", 32'(g[0]), 4'b0001);
    chk("fp_first", 32'(g[1]), 4'b0001);
    chk("dp_first", 32'(g[2]), 4'b0010);
    step();
    chk("rr_1", 32'(g[0]), 4'b0010);
    step();
    chk("rr_2", 32'(g[0]), 4'b0100);
    step();
    chk("rr_3", 32'(g[0]), 4'b1000);
    step();
    chk("rr_wrap", 32'(g[0]), 4'b0001);

    drain();
    drive(4'b0100, 3'd3, 1'b1);
    step();
    for (int i = 0; i < 7; i++) begin
      drive((i == 6) ? 4'b0000 : 4'b0100, 3'd3, (i >= 1 && i <= 3) ? 1'b0 : 1'b1);
      #1;
      chk("incr4_grant", 32'(g[0]), 4'b0100);
      chk("incr4_master", 32'(m[0]), 2);
      chk("incr4_last", 32'(l[0]), (i == 6) ? 1 : 0);
      step();
    end
    chk("incr4_release", 32'(g[0]), 0);

    drain();
    drive(4'b1000, 3'd5, 1'b1);
    step();
    for (int i = 0; i < 8; i++) begin
      drive((i >= 2) ? 4'b1001 : 4'b1000, 3'd5, 1'b1);
      #1;
      chk("fp_lock_grant", 32'(g[1]), 4'b1000);
      chk("fp_lock_last", 32'(l[1]), (i == 7) ? 1 : 0);
      step();
    end
    chk("fp_handover", 32'(g[1]), 4'b0001);
    chk("fp_handover_m", 32'(m[1]), 0);
    chk("dp_keep", 32'(g[2]), 4'b1000);

    drain();
    drive(4'b0010, 3'd1, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive((i == 4) ? 4'b0000 : 4'b0010, 3'd1, 1'b1);
      #1;
      chk("incr_drop_grant", 32'(g[0]), 4'b0010);
      chk("incr_drop_last", 32'(l[0]), (i == 4) ? 1 : 0);
      step();
    end
    chk("incr_drop_rel", 32'(g[0]), 0);

    drain();
    drive(4'b0010, 3'd1, 1'b1);
    step();
    for (int i = 0; i < 16; i++) begin
      drive(4'b0110, 3'd1, 1'b1);
      #1;
      chk("incr_cap_grant", 32'(g[0]), 4'b0010);
      chk("incr_cap_last", 32'(l[0]), (i == 15) ? 1 : 0);
      step();
    end
    chk("incr_cap_rr", 32'(g[0]), 4'b0100);

    drain();
    drive(4'hF, 3'd0, 1'b1);
    step();
    chk("dp_tie_grant", 32'(g[2]), 4'b0010);
    chk("dp_tie_master", 32'(m[2]), 1);

    drain();
    drive(4'hF, 3'd7, 1'b1);
    step();
    repeat (5) step();
    hreset_n = 1'b0;
    #1;
    chk("abort_last_rr", 32'(l[0]), 0);
    chk("abort_last_pb", 32'(l[3]), 0);
    step();
    hreset_n = 1'b1;
    #1;
    chk("abort_grant_rr", 32'(g[0]), 0);
    chk("abort_grant_pb", 32'(g[3]), 0);
    chk("abort_sel_rr", 32'(s[0]), 0);
    step();
    chk("abort_next_rr", 32'(g[0]), 4'b0001);
    chk("abort_next_pb", 32'(g[3]), 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("pb_rotate", 32'(g[3]), 32'(1 << (i % 4)));
      chk("rr_hold16", 32'(g[0]), 4'b0001);
    end

    repeat (400) begin
      hreset_n = ($urandom_range(99) != 0);
      hreq     = 4'($urandom);
      hburst   = 3'($urandom);
      hready   = ($urandom_range(3) != 0);
      hprior   = 8'($urandom);
      step();
    end
    hreset_n = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
